// File: rtl/line_buffer_5row_pkg.sv
// Shared constants for the 5-row line buffer feeding the 5x5 convolution stage.
// LB_LATENCY is what downstream sync alignment must match.
package line_buffer_5row_pkg;

    localparam int unsigned LB_COLORDEPTH  = 8;
    localparam int unsigned LB_SCREENWIDTH = 1600;
    localparam int unsigned LB_ADDR_W      = $clog2(LB_SCREENWIDTH);
    localparam int unsigned LB_LATENCY     = 2;
    localparam int unsigned LB_M_DEPTH     = 5;
    localparam int unsigned LB_LINES       = LB_M_DEPTH - 1;

    // Bit k set when tap k+1 (row n-1-k) holds data from the current frame.
    function automatic logic [LB_LINES-1:0] row_mask(input logic [2:0] rows);
        logic [LB_LINES-1:0] m;
        m = '0;
        for (int k = 0; k < int'(LB_LINES); k++) begin
            m[k] = (rows > 3'(k));
        end
        return m;
    endfunction

endpackage

// File: rtl/line_ram.sv
// Simple dual-port RAM with registered read; read-before-write on address collision.
module line_ram #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1600,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/line_buffer_5row.sv
// Raster stream to 5 vertically aligned taps per pixel; sync signals delayed to match.
// Four previous lines live in one RAM word per column, shifted down one row per write.
module line_buffer_5row
    import line_buffer_5row_pkg::*;
#(
    parameter int unsigned COLORDEPTH  = LB_COLORDEPTH,
    parameter int unsigned SCREENWIDTH = LB_SCREENWIDTH,
    parameter int unsigned M_DEPTH     = LB_M_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLORDEPTH-1:0] px_i,
    input  logic                  dv_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [COLORDEPTH-1:0] vect_o_0,
    output logic [COLORDEPTH-1:0] vect_o_1,
    output logic [COLORDEPTH-1:0] vect_o_2,
    output logic [COLORDEPTH-1:0] vect_o_3,
    output logic [COLORDEPTH-1:0] vect_o_4,
    output logic                  dv_o,
    output logic                  hs_o,
    output logic                  vs_o
);

    localparam int unsigned AW = (SCREENWIDTH > 1) ? $clog2(SCREENWIDTH) : 1;
    localparam int unsigned CD = COLORDEPTH;
    localparam logic [AW-1:0] COL_MAX = AW'(SCREENWIDTH - 1);

    if (M_DEPTH != 5) begin : g_depth_check
        $error("line_buffer_5row supports M_DEPTH = 5 only");
    end

    logic [AW-1:0]       col_q, col_d;
    logic                full_q, full_d;
    logic [2:0]          row_q, row_d;
    logic                accept;
    logic [LB_LINES-1:0] mask_d;

    logic [CD-1:0]       px_q;
    logic [AW-1:0]       addr_q;
    logic                wr_q, dv_q, hs_q, vs_q;
    logic [LB_LINES-1:0] mask_q;

    logic [4*CD-1:0]     ram_rdata, ram_wdata;

    // full_q marks that column SCREENWIDTH-1 was already taken on this line.
    always_comb begin
        col_d  = '0;
        full_d = 1'b0;
        if (dv_i) begin
            col_d  = (col_q == COL_MAX) ? col_q : col_q + AW'(1);
            full_d = full_q || (col_q == COL_MAX);
        end
        row_d = row_q;
        if (vs_i) begin
            row_d = '0;
        end else if (dv_q && !dv_i && (row_q < 3'(LB_LINES))) begin
            row_d = row_q + 3'd1;
        end
        accept = dv_i && !full_q;
        mask_d = accept ? row_mask(vs_i ? 3'd0 : row_q) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            full_q <= 1'b0;
            row_q  <= '0;
            px_q   <= '0;
            addr_q <= '0;
            wr_q   <= 1'b0;
            dv_q   <= 1'b0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            mask_q <= '0;
        end else begin
            col_q  <= col_d;
            full_q <= full_d;
            row_q  <= row_d;
            px_q   <= px_i;
            addr_q <= col_q;
            wr_q   <= accept;
            dv_q   <= dv_i;
            hs_q   <= hs_i;
            vs_q   <= vs_i;
            mask_q <= mask_d;
        end
    end

    // Oldest row falls off the top; newest pixel enters as row n-1.
    assign ram_wdata = {ram_rdata[3*CD-1:0], px_q};

    line_ram #(
        .WIDTH (4 * CD),
        .DEPTH (SCREENWIDTH),
        .AW    (AW)
    ) u_line_ram (
        .clk   (clk),
        .we    (wr_q),
        .waddr (addr_q),
        .wdata (ram_wdata),
        .raddr (col_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vect_o_0 <= '0;
            vect_o_1 <= '0;
            vect_o_2 <= '0;
            vect_o_3 <= '0;
            vect_o_4 <= '0;
            dv_o     <= 1'b0;
            hs_o     <= 1'b0;
            vs_o     <= 1'b0;
        end else begin
            vect_o_0 <= dv_q      ? px_q                     : '0;
            vect_o_1 <= mask_q[0] ? ram_rdata[1*CD-1:0*CD]   : '0;
            vect_o_2 <= mask_q[1] ? ram_rdata[2*CD-1:1*CD]   : '0;
            vect_o_3 <= mask_q[2] ? ram_rdata[3*CD-1:2*CD]   : '0;
            vect_o_4 <= mask_q[3] ? ram_rdata[4*CD-1:3*CD]   : '0;
            dv_o     <= dv_q;
            hs_o     <= hs_q;
            vs_o     <= vs_q;
        end
    end

endmodule

// File: tb/tb_line_buffer_5row.sv
// Scoreboard bench: a per-column pixel history model predicts every output cycle.
module tb_line_buffer_5row;
    import line_buffer_5row_pkg::*;

    localparam int SW = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] px;
    logic       dv, hs, vs;
    logic [7:0] vect_o_0, vect_o_1, vect_o_2, vect_o_3, vect_o_4;
    logic       dv_o, hs_o, vs_o;

    line_buffer_5row #(
        .COLORDEPTH  (8),
        .SCREENWIDTH (SW),
        .M_DEPTH     (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .px_i     (px),
        .dv_i     (dv),
        .hs_i     (hs),
        .vs_i     (vs),
        .vect_o_0 (vect_o_0),
        .vect_o_1 (vect_o_1),
        .vect_o_2 (vect_o_2),
        .vect_o_3 (vect_o_3),
        .vect_o_4 (vect_o_4),
        .dv_o     (dv_o),
        .hs_o     (hs_o),
        .vs_o     (vs_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] v0, v1, v2, v3, v4;
        logic       dv, hs, vs;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    int   cyc      = 0;

    // Model: every pixel ever written to a column, oldest first.
    logic [7:0] hist [SW][256];
    int         wcount [SW];
    int         idx     = 0;   // pixel index within the current dv run
    int         row     = 0;   // completed lines in this frame, saturating at 4
    bit         prev_dv = 1'b0;

    task automatic drive(input logic [7:0] p, input logic d, input logic h, input logic v);
        exp_t       e;
        logic [7:0] t [1:4];
        int         eff;
        px = p; dv = d; hs = h; vs = v;
        eff = v ? 0 : row;
        for (int k = 1; k <= 4; k++) begin
            t[k] = '0;
            if (d && idx < SW && eff >= k && wcount[idx] >= k) t[k] = hist[idx][wcount[idx] - k];
        end
        e.v0 = d ? p : 8'h00;
        e.v1 = t[1]; e.v2 = t[2]; e.v3 = t[3]; e.v4 = t[4];
        e.dv = d; e.hs = h; e.vs = v;
        sb.push_back(e);
        if (d && idx < SW) begin
            hist[idx][wcount[idx]] = p;
            wcount[idx]++;
        end
        if (v) row = 0;
        else if (prev_dv && !d && row < 4) row++;
        idx     = d ? idx + 1 : 0;
        prev_dv = d;
        @(posedge clk);
        #1;
    endtask

    // mode 1: px = row*16+col, otherwise random; vs_at = column raising vs (-1 for none)
    task automatic line(input int len, input int mode, input int r, input int vs_at);
        for (int c = 0; c < len; c++) begin
            drive(mode == 1 ? 8'(r * 16 + c) : 8'($urandom), 1'b1,
                  mode == 1 ? 1'b0 : 1'($urandom), c == vs_at);
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) drive(8'($urandom), 1'b0, i == 0, 1'b0);
    endtask

    task automatic vblank(input int n);
        for (int i = 0; i < n; i++) drive(8'($urandom), 1'b0, 1'($urandom), 1'b1);
    endtask

    always @(negedge clk) begin
        exp_t e, got;
        cyc++;
        if (mon_en) begin
            got.v0 = vect_o_0; got.v1 = vect_o_1; got.v2 = vect_o_2;
            got.v3 = vect_o_3; got.v4 = vect_o_4;
            got.dv = dv_o; got.hs = hs_o; got.vs = vs_o;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow cycle %0d: output present, no expected entry", cyc);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: got v=%h,%h,%h,%h,%h dv=%b hs=%b vs=%b; expected v=%h,%h,%h,%h,%h dv=%b hs=%b vs=%b",
                             cyc, got.v0, got.v1, got.v2, got.v3, got.v4, got.dv, got.hs, got.vs,
                             e.v0, e.v1, e.v2, e.v3, e.v4, e.dv, e.hs, e.vs);
                end
            end
        end
    end

    initial begin
        int len, vat;
        for (int c = 0; c < SW; c++) wcount[c] = 0;

        // Reset with random inputs: every output must be zero.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            px = 8'($urandom); dv = 1'($urandom); hs = 1'($urandom); vs = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({vect_o_0, vect_o_1, vect_o_2, vect_o_3, vect_o_4, dv_o, hs_o, vs_o} !== '0) begin
                n_fail++;
                $display("FAIL reset_state cycle %0d: got %h, expected 0", cyc,
                         {vect_o_0, vect_o_1, vect_o_2, vect_o_3, vect_o_4, dv_o, hs_o, vs_o});
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < int'(LB_LATENCY); i++) sb.push_back('0);
        mon_en = 1'b1;

        // Idle, then fill every column with several full lines of random data.
        for (int i = 0; i < 4; i++) drive(8'($urandom), 1'b0, 1'b0, 1'b0);
        vblank(2);
        for (int r = 0; r < 5; r++) begin
            line(SW, 0, r, -1);
            gap(2);
        end

        // Frame 1: px = row*16+col; line 2 is 10 pixels long (overflow columns).
        vblank(3);
        for (int r = 0; r < 6; r++) begin
            line(r == 2 ? 10 : SW, 1, r, -1);
            gap(2);
        end

        // Frame 2: vs pulse in the middle of line 3.
        vblank(2);
        for (int r = 0; r < 5; r++) begin
            line(SW, 1, r, r == 3 ? 4 : -1);
            gap(1 + r % 2);
        end

        // Random lines: varied lengths, gaps, hs and occasional vs pulses.
        for (int n = 0; n < 40; n++) begin
            len = $urandom_range(3, SW + 2);
            vat = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
            line(len, 0, 0, vat);
            gap($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) vblank($urandom_range(1, 3));
        end
        gap(2);

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        mon_en = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
